// File: rtl/xadac_fifo_pkg.sv
// Shared defaults for the xadac response-path FIFO.
// Instantiating blocks import this to keep their parameter defaults aligned with the FIFO.
package xadac_fifo_pkg;

  localparam int unsigned XadacFifoDefaultDepth       = 2;
  localparam bit          XadacFifoDefaultFallThrough = 1'b0;

endpackage : xadac_fifo_pkg

// File: rtl/xadac_fifo.sv
// Multi-entry valid/ready FIFO for the xadac response path (accelerator -> core).
// slv_ready is a function of registered occupancy only; optional fall-through when empty.
module xadac_fifo
  import xadac_fifo_pkg::*;
#(
  parameter int unsigned Depth       = XadacFifoDefaultDepth,
  parameter bit          FallThrough = XadacFifoDefaultFallThrough,
  parameter type         DataT       = logic
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       flush,
  input  DataT                       slv_data,
  input  logic                       slv_valid,
  output logic                       slv_ready,
  output DataT                       mst_data,
  output logic                       mst_valid,
  input  logic                       mst_ready,
  output logic [$clog2(Depth+1)-1:0] usage
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  localparam logic [CntW-1:0] FullCount = CntW'(Depth);
  localparam logic [PtrW-1:0] LastPtr   = PtrW'(Depth - 1);

  DataT            mem [Depth];
  logic [PtrW-1:0] rd_ptr;
  logic [PtrW-1:0] wr_ptr;

  logic full;
  logic empty;
  logic bypass;
  logic push;
  logic pop;
  logic wr_en;
  logic rd_adv;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    full      = (usage == FullCount);
    empty     = (usage == '0);
    bypass    = FallThrough && empty;
    slv_ready = !full;

    mst_valid = !empty;
    mst_data  = mem[rd_ptr];
    if (bypass) begin
      mst_valid = slv_valid;
      mst_data  = slv_data;
    end

    push = slv_valid && slv_ready;
    pop  = mst_valid && mst_ready;

    // A bypassed beat that is consumed immediately never touches storage or pointers.
    wr_en  = push && !(bypass && pop);
    rd_adv = pop && !bypass;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      usage  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      usage  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (rd_adv) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({wr_en, rd_adv})
        2'b10:   usage <= usage + 1'b1;
        2'b01:   usage <= usage - 1'b1;
        default: usage <= usage;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !flush) begin
      mem[wr_ptr] <= slv_data;
    end
  end

  if (Depth < 2) begin : g_depth_check
    $error("xadac_fifo: Depth must be at least 2");
  end

  a_usage_range : assert property (@(posedge clk) disable iff (!rstn)
    usage <= FullCount);

  a_no_push_full : assert property (@(posedge clk) disable iff (!rstn)
    !(push && full));

  if (!FallThrough) begin : g_no_pop_empty
    a_no_pop_empty : assert property (@(posedge clk) disable iff (!rstn)
      !(pop && empty));
  end

  a_head_stable : assert property (@(posedge clk) disable iff (!rstn)
    (mst_valid && !mst_ready && !flush && !bypass) |=> (mst_valid && $stable(mst_data)));

endmodule : xadac_fifo

// File: tb/tb_xadac_fifo.sv
// Directed and randomised checks of xadac_fifo across depth / fall-through variants.
module tb_xadac_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // u0: Depth=4, no fall-through
  logic       rstn0 = 1'b0, flush0 = 1'b0, sv0 = 1'b0, mr0 = 1'b0;
  logic [7:0] sd0 = '0;
  logic       sr0, mv0;
  logic [7:0] md0;
  logic [2:0] us0;

  // u1: Depth=3, no fall-through
  logic       rstn1 = 1'b0, flush1 = 1'b0, sv1 = 1'b0, mr1 = 1'b0;
  logic [7:0] sd1 = '0;
  logic       sr1, mv1;
  logic [7:0] md1;
  logic [1:0] us1;

  // u2: Depth=2, fall-through
  logic       rstn2 = 1'b0, flush2 = 1'b0, sv2 = 1'b0, mr2 = 1'b0;
  logic [7:0] sd2 = '0;
  logic       sr2, mv2;
  logic [7:0] md2;
  logic [1:0] us2;

  xadac_fifo #(.Depth(4), .FallThrough(1'b0), .DataT(logic [7:0])) u0 (
    .clk(clk), .rstn(rstn0), .flush(flush0), .slv_data(sd0), .slv_valid(sv0),
    .slv_ready(sr0), .mst_data(md0), .mst_valid(mv0), .mst_ready(mr0), .usage(us0));

  xadac_fifo #(.Depth(3), .FallThrough(1'b0), .DataT(logic [7:0])) u1 (
    .clk(clk), .rstn(rstn1), .flush(flush1), .slv_data(sd1), .slv_valid(sv1),
    .slv_ready(sr1), .mst_data(md1), .mst_valid(mv1), .mst_ready(mr1), .usage(us1));

  xadac_fifo #(.Depth(2), .FallThrough(1'b1), .DataT(logic [7:0])) u2 (
    .clk(clk), .rstn(rstn2), .flush(flush2), .slv_data(sd2), .slv_valid(sv2),
    .slv_ready(sr2), .mst_data(md2), .mst_valid(mv2), .mst_ready(mr2), .usage(us2));

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] q[$];
  logic       e_push, e_pop;

  initial begin
    // ---- 1: reset state and fill to full ----
    #2;
    check("t1_rst_mv", mv0, 0);
    check("t1_rst_sr", sr0, 1);
    check("t1_rst_us", us0, 0);
    rstn0 = 1'b1; rstn1 = 1'b1; rstn2 = 1'b1;
    cyc();
    for (int i = 0; i < 4; i++) begin
      sv0 = 1'b1; sd0 = 8'hA1 + 8'(i);
      cyc();
      if (i == 2) check("t1_sr_at3", sr0, 1);
    end
    sv0 = 1'b0;
    #1;
    check("t1_full_sr", sr0, 0);
    check("t1_full_us", us0, 4);
    check("t1_full_mv", mv0, 1);
    check("t1_full_md", md0, 8'hA1);

    // ---- 2: pop from full with a same-cycle push attempt ----
    mr0 = 1'b1; sv0 = 1'b1; sd0 = 8'hEE;
    cyc();
    sv0 = 1'b0; mr0 = 1'b0;
    #1;
    check("t2_us", us0, 3);
    check("t2_sr", sr0, 1);
    check("t2_md", md0, 8'hA2);
    mr0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("t2_drain_md", md0, 8'hA2 + 8'(i));
      check("t2_drain_mv", mv0, 1);
      cyc();
    end
    check("t2_empty_mv", mv0, 0);
    check("t2_empty_us", us0, 0);
    mr0 = 1'b0;

    // ---- 5: flush with a simultaneous push ----
    sv0 = 1'b1; sd0 = 8'h11; cyc();
    sd0 = 8'h22; cyc();
    check("t5_us2", us0, 2);
    flush0 = 1'b1; sd0 = 8'h77;
    #1;
    check("t5_sr_handshake", sr0, 1);
    cyc();
    flush0 = 1'b0; sv0 = 1'b0;
    #1;
    check("t5_us0", us0, 0);
    check("t5_mv0", mv0, 0);
    cyc();
    check("t5_mv_stay0", mv0, 0);
    sv0 = 1'b1; sd0 = 8'h33; cyc();
    sv0 = 1'b0;
    #1;
    check("t5_post_md", md0, 8'h33);
    check("t5_post_us", us0, 1);
    mr0 = 1'b1; cyc(); mr0 = 1'b0;
    check("t5_post_empty", us0, 0);

    // ---- 3: Depth=3 streaming with wrap ----
    mr1 = 1'b1;
    for (int k = 0; k < 10; k++) begin
      sv1 = 1'b1; sd1 = 8'(k);
      cyc();
      check("t3_md", md1, k);
      check("t3_mv", mv1, 1);
      check("t3_us", us1, 1);
    end
    sv1 = 1'b0;
    cyc();
    check("t3_end_us", us1, 0);
    check("t3_end_mv", mv1, 0);

    // ---- 4: fall-through when empty ----
    sv2 = 1'b1; sd2 = 8'h55; mr2 = 1'b1;
    #1;
    check("t4_ft_mv", mv2, 1);
    check("t4_ft_md", md2, 8'h55);
    check("t4_ft_sr", sr2, 1);
    cyc();
    sv2 = 1'b0;
    #1;
    check("t4_ft_us", us2, 0);
    check("t4_ft_mv_after", mv2, 0);
    sv2 = 1'b1; sd2 = 8'h66; mr2 = 1'b0;
    #1;
    check("t4_stall_mv", mv2, 1);
    check("t4_stall_md", md2, 8'h66);
    cyc();
    sv2 = 1'b0;
    #1;
    check("t4_stall_us", us2, 1);
    check("t4_stall_held", md2, 8'h66);
    mr2 = 1'b1; cyc(); mr2 = 1'b0;
    check("t4_drained", us2, 0);

    // ---- 6: random traffic with reset mid-burst ----
    q = {};
    for (int c = 0; c < 1000; c++) begin
      cyc();
      if (c == 500) begin
        #2;
        rstn0 = 1'b0;
        #1;
        check("t6_rst_mv", mv0, 0);
        check("t6_rst_sr", sr0, 1);
        check("t6_rst_us", us0, 0);
        q = {};
        sv0 = 1'b0; mr0 = 1'b0;
        #1;
        rstn0 = 1'b1;
        continue;
      end
      sv0 = 1'($urandom_range(1));
      mr0 = 1'($urandom_range(1));
      sd0 = 8'($urandom);
      #1;
      check("t6_us", us0, q.size());
      check("t6_mv", mv0, q.size() != 0);
      check("t6_sr", sr0, q.size() != 4);
      e_pop  = (q.size() != 0) && mr0;
      e_push = sv0 && (q.size() != 4);
      if (e_pop) begin
        check("t6_md", md0, q[0]);
        void'(q.pop_front());
      end
      if (e_push) q.push_back(sd0);
    end
    sv0 = 1'b0; mr0 = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_xadac_fifo
